// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution tap sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int unsigned K3  = 3;
  localparam int unsigned K5  = 5;
  localparam int unsigned KK3 = K3 * K3;
  localparam int unsigned KK5 = K5 * K5;

endpackage

// File: rtl/conv_delay_line.sv
// Fixed-depth shift register aligning tap flags and ofmd address with RAM read data.
module conv_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 12
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_tap_sequencer.sv
// Walks every output pixel and kernel tap, issuing ifmd/kw read addresses and
// delayed MAC control flags; pulses calc_done once the final tap drains.
module conv_tap_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IFMD_W = 16,
  parameter int unsigned IFMD_H = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned KW_AW  = 5,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_5x5,
  input  logic              en,
  output logic              busy,
  output logic [ADDR_W-1:0] ifmd_addr,
  output logic [KW_AW-1:0]  kw_addr,
  output logic              rd_issue,
  output logic              tap_valid,
  output logic              tap_first,
  output logic              tap_last,
  output logic [ADDR_W-1:0] ofmd_addr,
  output logic              calc_done
);

  localparam int unsigned XW  = $clog2(IFMD_W);
  localparam int unsigned YW  = $clog2(IFMD_H);
  localparam int unsigned DLW = ADDR_W + 4;

  seq_state_t state_q, state_d;
  logic              k5_q, k5_d;
  logic [2:0]        kx_q, kx_d, ky_q, ky_d;
  logic [XW-1:0]     ox_q, ox_d;
  logic [YW-1:0]     oy_q, oy_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, pix_base_q, pix_base_d;
  logic [ADDR_W-1:0] tap_row_q, tap_row_d, ifmd_cur_q, ifmd_cur_d;
  logic [ADDR_W-1:0] ofmd_cur_q, ofmd_cur_d, ifmd_hold_q;
  logic [KW_AW-1:0]  kw_cur_q, kw_cur_d, kw_hold_q;

  logic [2:0]        km1;
  logic [XW-1:0]     ow_m1;
  logic [YW-1:0]     oh_m1;
  logic              kx_end, ky_end, ox_end, oy_end, pix_end, last_tap, first_tap;
  logic              accept, issue;
  logic [DLW-1:0]    dl_d, dl_q;

  assign km1   = k5_q ? 3'(K5 - 1) : 3'(K3 - 1);
  assign ow_m1 = k5_q ? XW'(IFMD_W - K5) : XW'(IFMD_W - K3);
  assign oh_m1 = k5_q ? YW'(IFMD_H - K5) : YW'(IFMD_H - K3);

  assign kx_end    = (kx_q == km1);
  assign ky_end    = (ky_q == km1);
  assign ox_end    = (ox_q == ow_m1);
  assign oy_end    = (oy_q == oh_m1);
  assign pix_end   = kx_end && ky_end;
  assign last_tap  = pix_end && ox_end && oy_end;
  assign first_tap = (kx_q == 3'd0) && (ky_q == 3'd0);
  assign accept    = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue && last_tap) state_d = DRAIN;
      DRAIN:   if (calc_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    issue     = (state_q == RUN) && en;
    rd_issue  = issue;
    ifmd_addr = issue ? ifmd_cur_q : ifmd_hold_q;
    kw_addr   = issue ? kw_cur_q : kw_hold_q;
  end

  // Addresses advance by adds only: tap_row tracks (oy+ky)*IFMD_W+ox,
  // pix_base tracks oy*IFMD_W+ox, row_base tracks oy*IFMD_W.
  always_comb begin
    k5_d       = k5_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    row_base_d = row_base_q;
    pix_base_d = pix_base_q;
    tap_row_d  = tap_row_q;
    ifmd_cur_d = ifmd_cur_q;
    ofmd_cur_d = ofmd_cur_q;
    kw_cur_d   = kw_cur_q;
    if (accept) begin
      k5_d       = is_5x5;
      kx_d       = '0;
      ky_d       = '0;
      ox_d       = '0;
      oy_d       = '0;
      row_base_d = '0;
      pix_base_d = '0;
      tap_row_d  = '0;
      ifmd_cur_d = '0;
      ofmd_cur_d = '0;
      kw_cur_d   = '0;
    end else if (issue && !last_tap) begin
      if (!kx_end) begin
        kx_d       = kx_q + 3'd1;
        ifmd_cur_d = ifmd_cur_q + ADDR_W'(1);
        kw_cur_d   = kw_cur_q + KW_AW'(1);
      end else if (!ky_end) begin
        kx_d       = '0;
        ky_d       = ky_q + 3'd1;
        tap_row_d  = tap_row_q + ADDR_W'(IFMD_W);
        ifmd_cur_d = tap_row_d;
        kw_cur_d   = kw_cur_q + KW_AW'(1);
      end else begin
        kx_d       = '0;
        ky_d       = '0;
        kw_cur_d   = '0;
        ofmd_cur_d = ofmd_cur_q + ADDR_W'(1);
        if (!ox_end) begin
          ox_d       = ox_q + XW'(1);
          pix_base_d = pix_base_q + ADDR_W'(1);
        end else begin
          ox_d       = '0;
          oy_d       = oy_q + YW'(1);
          row_base_d = row_base_q + ADDR_W'(IFMD_W);
          pix_base_d = row_base_d;
        end
        tap_row_d  = pix_base_d;
        ifmd_cur_d = pix_base_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k5_q        <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      row_base_q  <= '0;
      pix_base_q  <= '0;
      tap_row_q   <= '0;
      ifmd_cur_q  <= '0;
      ofmd_cur_q  <= '0;
      kw_cur_q    <= '0;
      ifmd_hold_q <= '0;
      kw_hold_q   <= '0;
    end else begin
      k5_q       <= k5_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      row_base_q <= row_base_d;
      pix_base_q <= pix_base_d;
      tap_row_q  <= tap_row_d;
      ifmd_cur_q <= ifmd_cur_d;
      ofmd_cur_q <= ofmd_cur_d;
      kw_cur_q   <= kw_cur_d;
      if (issue) begin
        ifmd_hold_q <= ifmd_cur_q;
        kw_hold_q   <= kw_cur_q;
      end
    end
  end

  assign dl_d = {issue, issue && first_tap, issue && pix_end, issue && last_tap, ofmd_cur_q};

  conv_delay_line #(
    .DEPTH (RD_LAT),
    .W     (DLW)
  ) u_delay (
    .clk_i (clk),
    .clr_i (rst),
    .d_i   (dl_d),
    .q_o   (dl_q)
  );

  always_comb begin
    tap_valid = dl_q[ADDR_W+3];
    tap_first = dl_q[ADDR_W+3] && dl_q[ADDR_W+2];
    tap_last  = dl_q[ADDR_W+3] && dl_q[ADDR_W+1];
    calc_done = dl_q[ADDR_W+3] && dl_q[ADDR_W+1] && dl_q[ADDR_W];
    ofmd_addr = dl_q[ADDR_W-1:0];
  end

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Self-checking bench: known-address table, behavioural tap-walk model with random stalls,
// and directed multi-cycle corner cases (mid-run start, mid-run reset, back-to-back passes).
module tb_conv_tap_sequencer;

  localparam int unsigned IW  = 16;
  localparam int unsigned IH  = 16;
  localparam int unsigned AW  = 8;
  localparam int unsigned KAW = 5;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst, start, is_5x5, en;
  logic busy, rd_issue, tap_valid, tap_first, tap_last, calc_done;
  logic [AW-1:0]  ifmd_addr, ofmd_addr;
  logic [KAW-1:0] kw_addr;

  always #5 clk = ~clk;

  conv_tap_sequencer #(
    .IFMD_W (IW),
    .IFMD_H (IH),
    .ADDR_W (AW),
    .KW_AW  (KAW),
    .RD_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_5x5    (is_5x5),
    .en        (en),
    .busy      (busy),
    .ifmd_addr (ifmd_addr),
    .kw_addr   (kw_addr),
    .rd_issue  (rd_issue),
    .tap_valid (tap_valid),
    .tap_first (tap_first),
    .tap_last  (tap_last),
    .ofmd_addr (ofmd_addr),
    .calc_done (calc_done)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference tap walk from the addressing formulas
  int unsigned m_ifmd[$], m_kw[$], m_ofmd[$];
  bit          m_first[$], m_last[$];

  function automatic void build_model(input bit is5);
    int unsigned k, ow, oh;
    k  = is5 ? 5 : 3;
    ow = IW - k + 1;
    oh = IH - k + 1;
    m_ifmd.delete(); m_kw.delete(); m_ofmd.delete(); m_first.delete(); m_last.delete();
    for (int unsigned oy = 0; oy < oh; oy++)
      for (int unsigned ox = 0; ox < ow; ox++)
        for (int unsigned ky = 0; ky < k; ky++)
          for (int unsigned kx = 0; kx < k; kx++) begin
            m_ifmd.push_back((oy + ky) * IW + (ox + kx));
            m_kw.push_back(ky * k + kx);
            m_ofmd.push_back(oy * ow + ox);
            m_first.push_back(kx == 0 && ky == 0);
            m_last.push_back(kx == k - 1 && ky == k - 1);
          end
  endfunction

  // Captured DUT activity for the current pass
  int unsigned g_ifmd[$], g_kw[$], g_ofmd[$];
  bit          g_first[$], g_last[$];
  int          cyc, first_iss, last_iss, first_tv, last_tv, done_cyc;
  int unsigned done_cnt, leak;
  bit          busy_at_done, busy_c1;

  task automatic sample();
    if (rd_issue) begin
      if (g_ifmd.size() == 0) first_iss = cyc;
      last_iss = cyc;
      g_ifmd.push_back(int'(ifmd_addr));
      g_kw.push_back(int'(kw_addr));
    end
    if (tap_valid) begin
      if (g_first.size() == 0) first_tv = cyc;
      last_tv = cyc;
      g_first.push_back(tap_first);
      g_last.push_back(tap_last);
      g_ofmd.push_back(int'(ofmd_addr));
    end else if (tap_first || tap_last) begin
      leak++;
    end
    if (calc_done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (cyc == 1) busy_c1 = busy;
  endtask

  task automatic run_pass(input bit is5, input int unsigned stall_pct, input int mid_at,
                          input string tag);
    int unsigned n;
    build_model(is5);
    g_ifmd.delete(); g_kw.delete(); g_ofmd.delete(); g_first.delete(); g_last.delete();
    cyc = 0; first_iss = -1; last_iss = -1; first_tv = -1; last_tv = -1; done_cyc = -1;
    done_cnt = 0; leak = 0; busy_at_done = 0; busy_c1 = 0;
    @(posedge clk); #1;
    start = 1'b1; is_5x5 = is5; en = 1'b1;
    @(negedge clk); sample();
    for (int c = 1; c < 20000 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
      cyc    = c;
      start  = (c == mid_at);
      is_5x5 = (c == mid_at) ? !is5 : is5;
      en     = ($urandom_range(99) >= stall_pct);
      @(negedge clk); sample();
    end
    start = 1'b0;
    check({tag, "_calc_done_seen"}, done_cnt, 1);
    check({tag, "_busy_after_start"}, busy_c1, 1);
    check({tag, "_issue_count"}, g_ifmd.size(), m_ifmd.size());
    check({tag, "_tap_valid_count"}, g_first.size(), m_ifmd.size());
    n = (g_ifmd.size() < m_ifmd.size()) ? g_ifmd.size() : m_ifmd.size();
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s_ifmd[%0d]", tag, i), g_ifmd[i], m_ifmd[i]);
      check($sformatf("%s_kw[%0d]", tag, i), g_kw[i], m_kw[i]);
    end
    n = (g_first.size() < m_ifmd.size()) ? g_first.size() : m_ifmd.size();
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s_first[%0d]", tag, i), g_first[i], m_first[i]);
      check($sformatf("%s_last[%0d]", tag, i), g_last[i], m_last[i]);
      if (m_last[i]) check($sformatf("%s_ofmd[%0d]", tag, i), g_ofmd[i], m_ofmd[i]);
    end
    check({tag, "_flag_leak"}, leak, 0);
    check({tag, "_busy_at_done"}, busy_at_done, 1);
    check({tag, "_done_with_final_tap"}, done_cyc, last_tv);
    if (stall_pct == 0) begin
      check({tag, "_first_issue_cycle"}, first_iss, 1);
      check({tag, "_first_tap_cycle"}, first_tv, 1 + LAT);
      check({tag, "_done_latency"}, done_cyc - last_iss, LAT);
    end
  endtask

  task automatic idle_watch(input int unsigned n, input string tag);
    int unsigned extra = 0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0; en = $urandom_range(1);
      @(negedge clk);
      if (calc_done) extra++;
    end
    check({tag, "_no_extra_done"}, extra, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_rd_issue"}, rd_issue, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_issue"}, rd_issue, 0);
    check({tag, "_tap_flags"}, {tap_valid, tap_first, tap_last, calc_done}, 0);
    check({tag, "_ifmd_addr"}, ifmd_addr, 0);
    check({tag, "_kw_addr"}, kw_addr, 0);
    check({tag, "_ofmd_addr"}, ofmd_addr, 0);
  endtask

  typedef struct {
    bit          is5;
    int unsigned idx;
    int unsigned ifmd;
    int unsigned kw;
  } vec_t;

  vec_t tbl[14];

  task automatic apply_table(input bit is5, input string tag);
    for (int unsigned t = 0; t < 14; t++) begin
      if (tbl[t].is5 == is5) begin
        if (tbl[t].idx < g_ifmd.size()) begin
          check($sformatf("%s_tbl_ifmd[%0d]", tag, tbl[t].idx), g_ifmd[tbl[t].idx], tbl[t].ifmd);
          check($sformatf("%s_tbl_kw[%0d]", tag, tbl[t].idx), g_kw[tbl[t].idx], tbl[t].kw);
        end else begin
          check($sformatf("%s_tbl_present[%0d]", tag, tbl[t].idx), g_ifmd.size(), tbl[t].idx + 1);
        end
      end
    end
  endtask

  task automatic check_last_ofmd(input int unsigned exp, input string tag);
    if (g_ofmd.size() > 0) check({tag, "_final_ofmd"}, g_ofmd[g_ofmd.size()-1], exp);
    else                   check({tag, "_final_ofmd_present"}, 0, 1);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 1};
    tbl[2]  = '{0, 2, 2, 2};
    tbl[3]  = '{0, 3, 16, 3};
    tbl[4]  = '{0, 4, 17, 4};
    tbl[5]  = '{0, 5, 18, 5};
    tbl[6]  = '{0, 6, 32, 6};
    tbl[7]  = '{0, 7, 33, 7};
    tbl[8]  = '{0, 8, 34, 8};
    tbl[9]  = '{0, 9, 1, 0};
    tbl[10] = '{0, 1763, 255, 8};
    tbl[11] = '{1, 0, 0, 0};
    tbl[12] = '{1, 24, 68, 24};
    tbl[13] = '{1, 3599, 255, 24};

    rst = 1'b1; start = 1'b0; is_5x5 = 1'b0; en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // rst and start together: reset wins
    @(posedge clk); #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", busy, 0);

    run_pass(0, 0, -1, "k3");
    apply_table(0, "k3");
    check_last_ofmd(195, "k3");
    idle_watch(4, "k3");

    run_pass(1, 0, -1, "k5");
    apply_table(1, "k5");
    check_last_ofmd(143, "k5");
    idle_watch(4, "k5");

    run_pass(0, 50, -1, "k3_stall");
    idle_watch(3, "k3_stall");
    run_pass(1, 50, -1, "k5_stall");
    idle_watch(3, "k5_stall");

    run_pass(0, 0, 100, "mid_start");
    idle_watch(8, "mid_start");

    // Reset in the middle of a pass
    @(posedge clk); #1 start = 1'b1; is_5x5 = 1'b0; en = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    idle_watch(10, "rst_mid");

    run_pass(0, 25, -1, "after_rst");
    run_pass(1, 0, -1, "b2b");
    idle_watch(4, "b2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
